fht_stream_sequencer: RTL and testbench

- Streaming front/back end for fht_top. Accepts one sample per handshake and scatters the samples into the NUM_BANK transform RAM banks through the write ports.
- Pulses start and waits for the core's ready. Reads the result back out as a valid/ready stream.
- Replaces bench-side RAM init/readout with synthesisable hardware and generalises bank count, depth and width.

---
 rtl/fht_seq_pkg.sv | 36 +++
 rtl/fht_seq_skid.sv | 62 ++++++
 rtl/fht_stream_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_fht_stream_sequencer.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fht_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fht_seq_pkg
// Description : Shared types and helpers for the FHT stream sequencer:
//               FSM state encoding and a width-parameterised bit reversal.
// Revision    : 1.0 - initial release
// ============================================================================
package fht_seq_pkg;

  // Sequencer FSM states, explicit 3-bit encoding
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD      = 3'd1,
    S_START     = 3'd2,
    S_WAIT_BUSY = 3'd3,
    S_WAIT_RDY  = 3'd4,
    S_UNLOAD    = 3'd5
  } fht_seq_state_t;

  localparam int BITREV_MAX_W = 32;

  // Reverse the low i_w bits of i_v; bits at and above i_w come back as zero
  function automatic logic [BITREV_MAX_W-1:0] bitrev(
    input logic [BITREV_MAX_W-1:0] i_v,
    input int                      i_w
  );
    logic [BITREV_MAX_W-1:0] v_rev;
    v_rev = '0;
    for (int i = 0; i < BITREV_MAX_W; i++) begin
      if (i < i_w) v_rev[i] = i_v[i_w-1-i];
    end
    return v_rev;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fht_seq_skid.sv
`default_nettype none
// ============================================================================
// Module      : fht_seq_skid
// Description : Two-entry valid/ready output buffer with occupancy count.
//               Head entry drives the output and holds while stalled.
// Revision    : 1.0 - initial release
// ============================================================================
module fht_seq_skid
  import fht_seq_pkg::*;
#(
  parameter int DATA_W = 18
)(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [1:0]        o_count
);

  logic [DATA_W-1:0] r_mem [2];
  logic              r_wptr;
  logic              r_rptr;
  logic [1:0]        r_count;
  logic              w_pop;

  assign o_valid = (r_count != 2'd0);
  assign w_pop   = o_valid & i_ready;
  assign o_data  = r_mem[r_rptr];
  assign o_count = r_count;

  // Storage: write the incoming word into the slot at the write pointer
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wptr   <= 1'b0;
    end else if (i_push) begin
      r_mem[r_wptr] <= i_data;
      r_wptr        <= ~r_wptr;
    end
  end

  // Read pointer and occupancy; the caller guarantees no push when full
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rptr  <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (w_pop) r_rptr <= ~r_rptr;
      case ({i_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/fht_stream_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fht_stream_sequencer
// Description : Streaming front/back end for fht_top. Scatters an N-sample
//               input stream into NUM_BANK RAM banks, pulses the core start,
//               waits for completion and streams the result back out.
//               Optional macro FHT_SEQ_BITREV_OUT_EN: read results in
//               bit-reversed index order (natural-order output).
// Revision    : 1.0 - initial release
// ============================================================================
module fht_stream_sequencer
  import fht_seq_pkg::*;
#(
  parameter int D_BIT    = 18,
  parameter int A_BIT    = 9,
  parameter int NUM_BANK = 4
)(
  input  logic                      iCLK,
  input  logic                      iRESET,
  input  logic [D_BIT-1:0]          iS_DATA,
  input  logic                      iS_VALID,
  output logic                      oS_READY,
  output logic [NUM_BANK-1:0]       oWE,
  output logic [D_BIT-1:0]          oDATA_WR,
  output logic [A_BIT-1:0]          oADDR_WR,
  output logic                      oFHT_START,
  input  logic                      iFHT_RDY,
  output logic [A_BIT-1:0]          oADDR_RD,
  input  logic [NUM_BANK*D_BIT-1:0] iDATA_RD,
  output logic [D_BIT-1:0]          oM_DATA,
  output logic                      oM_VALID,
  input  logic                      iM_READY,
  output logic                      oBUSY,
  output logic                      oDONE
);

  localparam int LOG2_BANK = $clog2(NUM_BANK);
  localparam int N_BIT     = A_BIT + LOG2_BANK;

  fht_seq_state_t r_state, w_state_nxt;

  logic [N_BIT-1:0]     r_n;
  logic [N_BIT-1:0]     r_k;
  logic [N_BIT-1:0]     r_pop_cnt;
  logic [N_BIT-1:0]     w_r;
  logic                 r_all_issued;
  logic                 r_inflight;
  logic                 r_done;
  logic [LOG2_BANK-1:0] r_bank_d;
  logic [NUM_BANK-1:0]  r_we;
  logic [A_BIT-1:0]     r_addr_wr;
  logic [D_BIT-1:0]     r_data_wr;

  logic                 w_s_ready;
  logic                 w_s_hs;
  logic                 w_last_in;
  logic                 w_m_valid;
  logic                 w_m_hs;
  logic                 w_last_out;
  logic                 w_issue;
  logic [1:0]           w_occ;
  logic [2:0]           w_slots_used;
  logic [D_BIT-1:0]     w_bank_data [NUM_BANK];
  logic [D_BIT-1:0]     w_rd_data;
  logic [D_BIT-1:0]     w_m_data;

  // Input is refused during the oDONE cycle so a new frame starts after it
  assign w_s_ready  = ((r_state == S_IDLE) || (r_state == S_LOAD)) && !r_done;
  assign w_s_hs     = iS_VALID & w_s_ready;
  assign w_last_in  = w_s_hs & (&r_n);
  assign w_m_hs     = w_m_valid & iM_READY;
  assign w_last_out = w_m_hs & (&r_pop_cnt) & (r_state == S_UNLOAD);

  // Slots committed after this cycle: buffered words minus the one leaving
  // now, plus the read whose data lands next cycle. Counting the departing
  // word keeps one result per cycle flowing while downstream is ready.
  assign w_slots_used = {1'b0, w_occ} - {2'b00, w_m_hs} + {2'b00, r_inflight};
  assign w_issue      = (r_state == S_UNLOAD) && !r_all_issued && (w_slots_used < 3'd2);

`ifdef FHT_SEQ_BITREV_OUT_EN
  assign w_r = N_BIT'(bitrev(BITREV_MAX_W'(r_k), N_BIT));
`else
  assign w_r = r_k;
`endif

  // Split the packed bank read bus into one word per bank
  for (genvar b = 0; b < NUM_BANK; b++) begin : g_bank
    assign w_bank_data[b] = iDATA_RD[b*D_BIT +: D_BIT];
  end

  assign w_rd_data = w_bank_data[r_bank_d];

  assign oS_READY   = w_s_ready;
  assign oWE        = r_we;
  assign oDATA_WR   = r_data_wr;
  assign oADDR_WR   = r_addr_wr;
  assign oFHT_START = (r_state == S_START);
  assign oADDR_RD   = w_r[N_BIT-1:LOG2_BANK];
  assign oM_DATA    = w_m_data;
  assign oM_VALID   = w_m_valid;
  assign oBUSY      = (r_state != S_IDLE);
  assign oDONE      = r_done;

  fht_seq_skid #(
    .DATA_W (D_BIT)
  ) u_skid (
    .i_clk   (iCLK),
    .i_rst   (iRESET),
    .i_push  (r_inflight),
    .i_data  (w_rd_data),
    .o_data  (w_m_data),
    .o_valid (w_m_valid),
    .i_ready (iM_READY),
    .o_count (w_occ)
  );

  // FSM state register
  always_ff @(posedge iCLK) begin
    if (iRESET) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:      if (w_s_hs)     w_state_nxt = w_last_in ? S_START : S_LOAD;
      S_LOAD:      if (w_last_in)  w_state_nxt = S_START;
      S_START:                     w_state_nxt = S_WAIT_BUSY;
      S_WAIT_BUSY: if (!iFHT_RDY)  w_state_nxt = S_WAIT_RDY;
      S_WAIT_RDY:  if (iFHT_RDY)   w_state_nxt = S_UNLOAD;
      S_UNLOAD:    if (w_last_out) w_state_nxt = S_IDLE;
      default:                     w_state_nxt = S_IDLE;
    endcase
  end

  // Load path: register one bank write per accepted sample
  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      r_n       <= '0;
      r_we      <= '0;
      r_addr_wr <= '0;
      r_data_wr <= '0;
    end else begin
      r_we <= '0;
      if (w_s_hs) begin
        r_we      <= NUM_BANK'(1) << r_n[LOG2_BANK-1:0];
        r_addr_wr <= r_n[N_BIT-1:LOG2_BANK];
        r_data_wr <= iS_DATA;
        r_n       <= r_n + N_BIT'(1);
      end
    end
  end

  // Unload path: issue reads, track the in-flight read and count results
  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      r_k          <= '0;
      r_all_issued <= 1'b0;
      r_inflight   <= 1'b0;
      r_bank_d     <= '0;
      r_pop_cnt    <= '0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_k      <= r_k + N_BIT'(1);
        r_bank_d <= w_r[LOG2_BANK-1:0];
        if (&r_k) r_all_issued <= 1'b1;
      end
      if (w_m_hs)     r_pop_cnt    <= r_pop_cnt + N_BIT'(1);
      if (w_last_out) r_all_issued <= 1'b0;
    end
  end

  // Done pulse on the cycle after the final result handshake
  always_ff @(posedge iCLK) begin
    if (iRESET) r_done <= 1'b0;
    else        r_done <= w_last_out;
  end

endmodule
`default_nettype wire

// File: tb/tb_fht_stream_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fht_stream_sequencer
// Description : Self-checking bench for fht_stream_sequencer with a banked
//               RAM model, a core stub and a result scoreboard. Expected
//               order follows FHT_SEQ_BITREV_OUT_EN when it is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fht_stream_sequencer;

  localparam int D    = 18;
  localparam int A    = 9;
  localparam int NB   = 4;
  localparam int NBIT = 11;
  localparam int N    = 2048;
`ifdef FHT_SEQ_BITREV_OUT_EN
  localparam bit REV  = 1'b1;
`else
  localparam bit REV  = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [D-1:0]    s_data;
  logic            s_valid;
  logic            s_ready;
  logic [NB-1:0]   we;
  logic [D-1:0]    data_wr;
  logic [A-1:0]    addr_wr;
  logic            fht_start;
  logic            fht_rdy;
  logic [A-1:0]    addr_rd;
  logic [NB*D-1:0] data_rd;
  logic [D-1:0]    m_data;
  logic            m_valid;
  logic            m_ready;
  logic            busy;
  logic            done;

  always #5 clk = ~clk;

  fht_stream_sequencer #(.D_BIT(D), .A_BIT(A), .NUM_BANK(NB)) dut (
    .iCLK(clk), .iRESET(rst), .iS_DATA(s_data), .iS_VALID(s_valid),
    .oS_READY(s_ready), .oWE(we), .oDATA_WR(data_wr), .oADDR_WR(addr_wr),
    .oFHT_START(fht_start), .iFHT_RDY(fht_rdy), .oADDR_RD(addr_rd),
    .iDATA_RD(data_rd), .oM_DATA(m_data), .oM_VALID(m_valid),
    .iM_READY(m_ready), .oBUSY(busy), .oDONE(done)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Banked RAM model with one-cycle registered read
  logic [D-1:0] mem [NB][2**A];
  always @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (we[b]) mem[b][addr_wr] <= data_wr;
      data_rd[b*D +: D] <= mem[b][addr_rd];
    end
  end

  function automatic int brev(input int k);
    logic [NBIT-1:0] a, r;
    a = k[NBIT-1:0];
    for (int i = 0; i < NBIT; i++) r[i] = a[NBIT-1-i];
    return int'(r);
  endfunction

  // Scoreboards
  int           wq_idx[$];
  logic [D-1:0] wq_data[$];
  logic [D-1:0] exp_q[$];
  logic [D-1:0] samp [N];

  bit           ramp = 1'b0;
  bit           rand_ready = 1'b0;
  int           last_acc_cyc, start_cyc, rise_cyc, first_cyc, last_res_cyc;
  int           start_cnt, done_cnt, res_cnt;
  bit           prev_stall = 1'b0;
  logic [D-1:0] prev_data;
  int           w_idx;
  logic [D-1:0] w_d, e_d;

  // Write-port monitor: each oWE must match the oldest accepted sample
  always @(negedge clk) begin
    if (we != '0) begin
      if (wq_idx.size() == 0) chk("we_unexpected", 32'(we), 0);
      else begin
        w_idx = wq_idx.pop_front();
        w_d   = wq_data.pop_front();
        chk("we_bank", 32'(we), 32'(1) << (w_idx % NB));
        chk("we_addr", 32'(addr_wr), 32'(w_idx / NB));
        chk("we_data", 32'(data_wr), 32'(w_d));
        if (w_idx == 0) begin
          chk("we0_bank", 32'(we), 1);
          chk("we0_addr", 32'(addr_wr), 0);
        end
        if (w_idx == 6 && ramp) begin
          chk("n6_we", 32'(we), 32'b0100);
          chk("n6_addr", 32'(addr_wr), 1);
          chk("n6_data", 32'(data_wr), 6);
        end
      end
    end
  end

  // Result, start and done monitor
  always @(negedge clk) begin
    if (rst) prev_stall = 1'b0;
    else begin
      if (prev_stall) begin
        chk("stall_valid", 32'(m_valid), 1);
        chk("stall_data", 32'(m_data), 32'(prev_data));
      end
      if (m_valid && first_cyc < 0) first_cyc = cyc;
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) chk("result_overrun", 32'(m_valid), 0);
        else begin
          e_d = exp_q.pop_front();
          chk("result", 32'(m_data), 32'(e_d));
          if (ramp && res_cnt == 1)    chk("res_k1", 32'(m_data), REV ? 1024 : 1);
          if (ramp && res_cnt == 2)    chk("res_k2", 32'(m_data), REV ? 512 : 2);
          if (ramp && res_cnt == 2047) chk("res_k2047", 32'(m_data), 2047);
        end
        res_cnt++;
        last_res_cyc = cyc;
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      if (done) begin
        done_cnt++;
        chk("done_gap", 32'(cyc - last_res_cyc), 1);
        chk("busy_at_done", 32'(busy), 0);
      end
      if (fht_start) begin
        start_cnt++;
        start_cyc = cyc;
      end
    end
  end

  // Downstream ready driver
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      m_ready = rand_ready ? 1'($urandom % 2) : 1'b1;
    end
  end

  // Feed samples with valid held high; stop_at >= 0 asserts reset there
  task automatic load(input bit is_ramp, input int stop_at);
    int idx = 0;
    int wait_cnt = 0;
    ramp = is_ramp;
    @(posedge clk); #1;
    s_valid = 1'b1;
    s_data  = is_ramp ? D'(idx) : D'($urandom);
    while (idx < N) begin
      @(negedge clk);
      if (s_ready) begin
        samp[idx] = s_data;
        wq_idx.push_back(idx);
        wq_data.push_back(s_data);
        last_acc_cyc = cyc;
        idx++;
        wait_cnt = 0;
        @(posedge clk); #1;
        if (idx == stop_at) begin
          rst = 1'b1;
          s_valid = 1'b0;
          return;
        end
        s_data = is_ramp ? D'(idx) : D'($urandom);
        if (idx == N) s_valid = 1'b0;
      end else begin
        wait_cnt++;
        if (wait_cnt > 10) begin
          chk("s_ready_timeout", 32'(s_ready), 1);
          s_valid = 1'b0;
          return;
        end
      end
    end
  endtask

  // One full frame: load, core stub, unload
  task automatic frame(input bit is_ramp, input bit rnd_ready);
    int t;
    start_cnt = 0; done_cnt = 0; res_cnt = 0; first_cyc = -1;
    rand_ready = rnd_ready;
    load(is_ramp, -1);
    for (int k = 0; k < N; k++) exp_q.push_back(samp[REV ? brev(k) : k]);
    t = 0;
    while (start_cnt == 0 && t < 10) begin @(posedge clk); #1; t++; end
    chk("start_seen", 32'(start_cnt), 1);
    chk("start_latency", 32'(start_cyc - last_acc_cyc), 1);
    while (cyc < start_cyc + 3)  begin @(posedge clk); #1; end
    fht_rdy = 1'b0;
    while (cyc < start_cyc + 43) begin @(posedge clk); #1; end
    fht_rdy  = 1'b1;
    rise_cyc = cyc;
    t = 0;
    while (done_cnt == 0 && t < 20000) begin @(posedge clk); #1; t++; end
    repeat (3) begin @(posedge clk); #1; end
    chk("done_once", 32'(done_cnt), 1);
    chk("start_once", 32'(start_cnt), 1);
    chk("result_count", 32'(res_cnt), N);
    chk("first_valid_latency", 32'(first_cyc - rise_cyc), 3);
    if (!rnd_ready) chk("full_rate_span", 32'(last_res_cyc - first_cyc), N - 1);
    chk("busy_after", 32'(busy), 0);
    chk("exp_left", 32'(exp_q.size()), 0);
    rand_ready = 1'b0;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_data = '0; fht_rdy = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_we", 32'(we), 0);
    chk("rst_start", 32'(fht_start), 0);
    chk("rst_valid", 32'(m_valid), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_addr_wr", 32'(addr_wr), 0);
    chk("rst_data_wr", 32'(data_wr), 0);
    chk("rst_addr_rd", 32'(addr_rd), 0);
    chk("rst_m_data", 32'(m_data), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    frame(1'b1, 1'b0);
    frame(1'b0, 1'b1);

    // Abort a load at sample 700
    load(1'b0, 700);
    @(posedge clk);
    @(negedge clk);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_we", 32'(we), 0);
    #1;
    rst = 1'b0;
    wq_idx.delete();
    wq_data.delete();

    frame(1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
